// File: rtl/mips32_pkg.sv
// Shared mips32 pipeline constants and the hazard controller state type.
package mips32_pkg;

    localparam int          REG_W    = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> hazard controller bundle: ID/EX hazard inputs and pipeline register controls.
interface pipeline_ctrl_if #(
    parameter int REG_W = mips32_pkg::REG_W
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_mdu_start;
    logic             id_mdu_read;
    logic [REG_W-1:0] ex_rt;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mdu_busy;

    // Datapath side: reports decoded fields, consumes controls.
    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, id_mdu_start, id_mdu_read,
               ex_rt, ex_mem_read, ex_branch_taken,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush, mdu_busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, id_mdu_start, id_mdu_read,
               ex_rt, ex_mem_read, ex_branch_taken,
        output pc_we, if_id_we, if_id_flush, id_ex_flush, mdu_busy
    );
endinterface

// File: rtl/mdu_busy_timer.sv
// Tracks the multi-cycle mult/div busy window: RUN while idle, MDU_WAIT for MDU_LAT cycles after start.
module mdu_busy_timer
    import mips32_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);
    localparam int               CNT_W    = $clog2(MDU_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MDU_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Start is only ever presented in RUN: a start while busy is stalled upstream.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (start) begin
                    cnt_d   = LAT_INIT;
                    state_d = MDU_WAIT;
                end
            end
            MDU_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == MDU_WAIT);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// mips32 hazard/sequencing controller: load-use, branch, jump and MDU stalls/flushes.
// Define PIPELINE_CTRL_PERF_EN to add stall_cycles / flush_cycles performance counters.
module pipeline_ctrl
    import mips32_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int REG_W   = mips32_pkg::REG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_ctrl_if.slave       bus
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_cycles
`endif
);
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             timer_busy, mdu_busy;
    logic             load_use, mdu_hz, stall, mdu_accept;
    logic             pc_we, if_id_we, if_id_flush, id_ex_flush;

    assign id_rs = bus.id_rs;
    assign id_rt = bus.id_rt;
    assign ex_rt = bus.ex_rt;

    mdu_busy_timer #(.MDU_LAT(MDU_LAT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_accept),
        .busy  (timer_busy)
    );

    // Busy is forced low for the whole reset window, including the first reset cycle.
    assign mdu_busy = timer_busy && !rst;

    assign load_use = bus.ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                      ((ex_rt == id_rs) || (bus.id_uses_rt && (ex_rt == id_rt)));
    assign mdu_hz   = mdu_busy && (bus.id_mdu_read || bus.id_mdu_start);
    assign stall    = load_use || mdu_hz;

    assign mdu_accept = bus.id_mdu_start && !stall && !bus.ex_branch_taken && !rst;

    always_comb begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.id_jump) begin
            if_id_flush = 1'b1;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.if_id_we    = if_id_we;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.mdu_busy    = mdu_busy;

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && !bus.ex_branch_taken) stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush)                   flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised and directed bench for pipeline_ctrl (MDU_LAT = 4) against a cycle-indexed reference model.
module tb_pipeline_ctrl;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   t_iss  = -1000;
    int   m_stall_cnt = 0;
    int   m_flush_cnt = 0;

    pipeline_ctrl_if #(.REG_W(5)) bus ();

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
    pipeline_ctrl #(.MDU_LAT(LAT), .REG_W(5)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave),
        .stall_cycles (stall_cycles), .flush_cycles (flush_cycles)
    );
`else
    pipeline_ctrl #(.MDU_LAT(LAT), .REG_W(5)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
`endif

    always #5 clk = ~clk;

    // MDU is busy in cycle c when it was accepted in an earlier cycle no more than LAT ago.
    function automatic logic m_busy();
        return !rst && (cyc > t_iss) && (cyc <= t_iss + LAT);
    endfunction

    function automatic logic m_stall();
        logic lu;
        lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
             ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        return lu || (m_busy() && (bus.id_mdu_read || bus.id_mdu_start));
    endfunction

    // {pc_we, if_id_we, if_id_flush, id_ex_flush, mdu_busy}
    function automatic logic [4:0] m_out();
        if (rst)                 return 5'b00110;
        if (bus.ex_branch_taken) return {4'b1111, m_busy()};
        if (m_stall())           return {4'b0001, m_busy()};
        if (bus.id_jump)         return {4'b1110, m_busy()};
        return {4'b1100, m_busy()};
    endfunction

    function automatic logic [4:0] d_out();
        return {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush, bus.mdu_busy};
    endfunction

    task automatic idle();
        bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_uses_rt = 1'b0;
        bus.id_jump = 1'b0; bus.id_mdu_start = 1'b0; bus.id_mdu_read = 1'b0;
        bus.ex_rt = 5'd3; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
    endtask

    // Advance one cycle, updating the model from the inputs present before the edge.
    task automatic tick();
        logic acc, st, fl;
        st  = m_stall();
        acc = !rst && bus.id_mdu_start && !st && !bus.ex_branch_taken;
        fl  = !rst && (bus.ex_branch_taken || (!st && bus.id_jump));
        @(posedge clk);
        if (rst) begin
            t_iss = -1000; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (acc) t_iss = cyc;
            if (st && !bus.ex_branch_taken) m_stall_cnt++;
            if (fl) m_flush_cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (d_out() !== 5'b00110) $display("FAIL reset_outputs cyc%0d got %b want %b", i, d_out(), 5'b00110);
            else passed++;
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (d_out() !== 5'b11000) $display("FAIL reset_release got %b want %b", d_out(), 5'b11000);
        else passed++;
        tick();
    endtask

    task automatic test_load_use();
        logic [4:0] want [3];
        want[0] = 5'b00010; want[1] = 5'b11000; want[2] = 5'b11000;
        for (int k = 0; k < 3; k++) begin
            idle();
            bus.ex_mem_read = 1'b1;
            bus.ex_rt = (k == 1) ? 5'd0 : 5'd8;
            if (k == 2) begin bus.id_rt = 5'd8; bus.id_uses_rt = 1'b0; end
            else        begin bus.id_rs = 5'd8; end
            @(negedge clk);
            total++;
            if (d_out() !== want[k] || d_out() !== m_out())
                $display("FAIL load_use case%0d got %b want %b", k, d_out(), want[k]);
            else passed++;
            tick();
        end
        idle();
    endtask

    task automatic test_branch_over_stall();
        idle();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
        bus.ex_branch_taken = 1'b1; bus.id_jump = 1'b1;
        @(negedge clk);
        total++;
        if (d_out() !== 5'b11110) $display("FAIL branch_over_stall got %b want %b", d_out(), 5'b11110);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_mdu();
        // mfhi held from cycle 1: stalled cycles 1..4, released cycle 5.
        idle(); bus.id_mdu_start = 1'b1;
        @(negedge clk);
        total++;
        if (d_out() !== 5'b11000) $display("FAIL mdu_issue got %b want %b", d_out(), 5'b11000);
        else passed++;
        tick();
        bus.id_mdu_start = 1'b0; bus.id_mdu_read = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if (d_out() !== ((c <= LAT) ? 5'b00011 : 5'b11000))
                $display("FAIL mdu_mfhi cyc%0d got %b want %b", c, d_out(), (c <= LAT) ? 5'b00011 : 5'b11000);
            else passed++;
            tick();
        end
        // Second mult at cycle 2 stalls without reloading the counter.
        idle(); bus.id_mdu_start = 1'b1;
        tick();
        bus.id_mdu_start = 1'b0;
        tick();
        bus.id_mdu_start = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if (d_out() !== m_out() || (c == 5 && d_out() !== 5'b11000))
                $display("FAIL mdu_restart cyc%0d got %b want %b", c, d_out(), m_out());
            else passed++;
            tick();
        end
        idle();
        repeat (LAT + 1) tick();
    endtask

    task automatic test_jump();
        idle(); bus.id_jump = 1'b1;
        @(negedge clk);
        total++;
        if (d_out() !== 5'b11100) $display("FAIL jump_plain got %b want %b", d_out(), 5'b11100);
        else passed++;
        tick();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
        @(negedge clk);
        total++;
        if (d_out() !== 5'b00010) $display("FAIL jump_stall got %b want %b", d_out(), 5'b00010);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_reset_mid_mdu();
        idle(); bus.id_mdu_start = 1'b1;
        tick();
        bus.id_mdu_start = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.mdu_busy !== 1'b0) $display("FAIL rst_mid_mdu_during got %b want 0", bus.mdu_busy);
        else passed++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mdu_busy !== 1'b0 || d_out() !== 5'b11000)
            $display("FAIL rst_mid_mdu_after got %b want %b", d_out(), 5'b11000);
        else passed++;
`ifdef PIPELINE_CTRL_PERF_EN
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rs = 5'd4;
        repeat (3) tick();
        idle();
        @(negedge clk);
        total++;
        if (stall_cycles !== 32'd3) $display("FAIL perf_stall got %0d want 3", stall_cycles);
        else passed++;
`endif
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst                 = ($urandom_range(0, 99) < 3);
            bus.id_rs           = 5'($urandom_range(0, 3));
            bus.id_rt           = 5'($urandom_range(0, 3));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.id_jump         = ($urandom_range(0, 99) < 15);
            bus.id_mdu_start    = ($urandom_range(0, 99) < 15);
            bus.id_mdu_read     = ($urandom_range(0, 99) < 20);
            bus.ex_rt           = 5'($urandom_range(0, 3));
            bus.ex_mem_read     = ($urandom_range(0, 99) < 25);
            bus.ex_branch_taken = ($urandom_range(0, 99) < 10);
            @(negedge clk);
            total++;
            if (d_out() !== m_out()) $display("FAIL random cyc%0d got %b want %b", i, d_out(), m_out());
            else passed++;
`ifdef PIPELINE_CTRL_PERF_EN
            total++;
            if (stall_cycles !== 32'(m_stall_cnt) || flush_cycles !== 32'(m_flush_cnt))
                $display("FAIL random_perf cyc%0d got %0d/%0d want %0d/%0d", i,
                         stall_cycles, flush_cycles, m_stall_cnt, m_flush_cnt);
            else passed++;
`endif
            tick();
        end
        rst = 1'b0; idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_branch_over_stall();
        test_mdu();
        test_jump();
        test_reset_mid_mdu();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
